// File: rtl/sdspi_cmd_seq.sv
// SD-card SPI command sequencer.
// Frames one SD command (index, argument, hardware CRC7), pushes it byte by
// byte into the SPI byte engine, polls for the R1 response, then releases CS
// and reports the response with a one-cycle resp_valid_o pulse.
// Exactly one byte is ever in flight: after a tx handshake the sequencer
// waits for the matching rx pulse before offering the next byte.

module sdspi_cmd_seq #(
    parameter int RESP_POLL_MAX = 8,
    parameter int PRE_BYTES     = 1,
    parameter int POST_BYTES    = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        card_present_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [5:0]  cmd_idx_i,
    input  logic [31:0] cmd_arg_i,
    output logic        resp_valid_o,
    output logic [7:0]  resp_r1_o,
    output logic        resp_timeout_o,
    output logic        spi_cs_n_o,
    output logic        spi_tx_valid_o,
    input  logic        spi_tx_ready_i,
    output logic [7:0]  spi_tx_byte_o,
    input  logic        spi_rx_valid_i,
    input  logic [7:0]  spi_rx_byte_i
);

    localparam int PCW = $clog2(RESP_POLL_MAX + 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_CMD  = 3'd2;
    localparam logic [2:0] ST_POLL = 3'd3;
    localparam logic [2:0] ST_POST = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    localparam logic [3:0]     PRE_LAST  = 4'(PRE_BYTES);
    localparam logic [3:0]     POST_LAST = 4'(POST_BYTES);
    localparam logic [PCW-1:0] POLL_LAST = PCW'(RESP_POLL_MAX);

    // CRC7 (x^7 + x^3 + 1), one byte, MSB first.
    function automatic logic [6:0] crc7_upd(input logic [6:0] crc_in, input logic [7:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb  = crc[6] ^ data[i];
            crc = {crc[5:0], 1'b0};
            if (fb) begin
                crc = crc ^ 7'h09;
            end
        end
        return crc;
    endfunction

    // Byte number sel of the 6-byte command frame.
    function automatic logic [7:0] cmd_byte(input logic [3:0] sel, input logic [5:0] idx,
                                            input logic [31:0] arg, input logic [6:0] crc);
        logic [7:0] b;
        case (sel)
            4'd0:    b = {2'b01, idx};
            4'd1:    b = arg[31:24];
            4'd2:    b = arg[23:16];
            4'd3:    b = arg[15:8];
            4'd4:    b = arg[7:0];
            4'd5:    b = {crc, 1'b1};
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    logic [2:0]     state_r;
    logic [5:0]     idx_r;
    logic [31:0]    arg_r;
    logic [6:0]     crc_r;
    logic [3:0]     byte_cnt_r;
    logic [PCW-1:0] poll_cnt_r;
    logic           wait_rx_r;
    logic           tx_valid_r;
    logic [7:0]     tx_byte_r;
    logic           cs_n_r;
    logic           cmd_ready_r;
    logic           resp_valid_r;
    logic [7:0]     resp_r1_r;
    logic           resp_timeout_r;
    logic [7:0]     pend_r1_r;
    logic           pend_to_r;

    logic           sending_s;
    logic           offer_s;
    logic           hs_s;
    logic           rx_s;
    logic [7:0]     next_byte_s;
    logic [PCW-1:0] poll_inc_s;
    logic           poll_hit_s;
    logic           poll_end_s;
    logic [7:0]     poll_r1_s;

    // Handshake/offer decode and R1 poll decision for the current cycle.
    always_comb begin
        sending_s   = 1'b0;
        next_byte_s = 8'hFF;
        poll_r1_s   = 8'hFF;
        case (state_r)
            ST_PRE, ST_CMD, ST_POLL, ST_POST: sending_s = 1'b1;
            default:                          sending_s = 1'b0;
        endcase
        offer_s    = sending_s & ~tx_valid_r & ~wait_rx_r;
        hs_s       = tx_valid_r & spi_tx_ready_i;
        rx_s       = wait_rx_r & spi_rx_valid_i;
        poll_inc_s = poll_cnt_r + PCW'(1);
        poll_hit_s = ~spi_rx_byte_i[7];
        poll_end_s = poll_hit_s | (poll_inc_s == POLL_LAST);
        if (poll_hit_s) begin
            poll_r1_s = spi_rx_byte_i;
        end else begin
            poll_r1_s = 8'hFF;
        end
        if (state_r == ST_CMD) begin
            next_byte_s = cmd_byte(byte_cnt_r, idx_r, arg_r, crc_r);
        end else begin
            next_byte_s = 8'hFF;
        end
    end

    // Sequencer state, SPI byte stream, chip select and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r        <= ST_IDLE;
            idx_r          <= 6'd0;
            arg_r          <= 32'd0;
            crc_r          <= 7'd0;
            byte_cnt_r     <= 4'd0;
            poll_cnt_r     <= '0;
            wait_rx_r      <= 1'b0;
            tx_valid_r     <= 1'b0;
            tx_byte_r      <= 8'hFF;
            cs_n_r         <= 1'b1;
            cmd_ready_r    <= 1'b1;
            resp_valid_r   <= 1'b0;
            resp_r1_r      <= 8'hFF;
            resp_timeout_r <= 1'b0;
            pend_r1_r      <= 8'hFF;
            pend_to_r      <= 1'b0;
        end else begin
            resp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_r) begin
                        idx_r       <= cmd_idx_i;
                        arg_r       <= cmd_arg_i;
                        crc_r       <= 7'd0;
                        byte_cnt_r  <= 4'd0;
                        poll_cnt_r  <= '0;
                        cmd_ready_r <= 1'b0;
                        if (!card_present_i) begin
                            resp_r1_r      <= 8'hFF;
                            resp_timeout_r <= 1'b1;
                            resp_valid_r   <= 1'b1;
                            state_r        <= ST_DONE;
                        end else begin
                            cs_n_r  <= 1'b0;
                            state_r <= (PRE_BYTES == 0) ? ST_CMD : ST_PRE;
                        end
                    end
                end
                ST_PRE, ST_CMD, ST_POLL, ST_POST: begin
                    if (hs_s) begin
                        tx_valid_r <= 1'b0;
                        wait_rx_r  <= 1'b1;
                        // CRC covers the first five frame bytes as they are handshaken.
                        if (state_r == ST_CMD && byte_cnt_r < 4'd5) begin
                            crc_r <= crc7_upd(crc_r, tx_byte_r);
                        end
                    end else if (rx_s) begin
                        wait_rx_r <= 1'b0;
                        case (state_r)
                            ST_PRE: begin
                                if (byte_cnt_r + 4'd1 == PRE_LAST) begin
                                    byte_cnt_r <= 4'd0;
                                    state_r    <= ST_CMD;
                                end else begin
                                    byte_cnt_r <= byte_cnt_r + 4'd1;
                                end
                            end
                            ST_CMD: begin
                                if (byte_cnt_r == 4'd5) begin
                                    byte_cnt_r <= 4'd0;
                                    poll_cnt_r <= '0;
                                    state_r    <= ST_POLL;
                                end else begin
                                    byte_cnt_r <= byte_cnt_r + 4'd1;
                                end
                            end
                            ST_POLL: begin
                                poll_cnt_r <= poll_inc_s;
                                if (poll_end_s) begin
                                    pend_r1_r  <= poll_r1_s;
                                    pend_to_r  <= ~poll_hit_s;
                                    byte_cnt_r <= 4'd0;
                                    if (POST_BYTES == 0) begin
                                        cs_n_r         <= 1'b1;
                                        resp_r1_r      <= poll_r1_s;
                                        resp_timeout_r <= ~poll_hit_s;
                                        resp_valid_r   <= 1'b1;
                                        state_r        <= ST_DONE;
                                    end else begin
                                        state_r <= ST_POST;
                                    end
                                end
                            end
                            ST_POST: begin
                                if (byte_cnt_r + 4'd1 == POST_LAST) begin
                                    cs_n_r         <= 1'b1;
                                    resp_r1_r      <= pend_r1_r;
                                    resp_timeout_r <= pend_to_r;
                                    resp_valid_r   <= 1'b1;
                                    state_r        <= ST_DONE;
                                end else begin
                                    byte_cnt_r <= byte_cnt_r + 4'd1;
                                end
                            end
                            default: state_r <= ST_IDLE;
                        endcase
                    end else if (offer_s) begin
                        tx_valid_r <= 1'b1;
                        tx_byte_r  <= next_byte_s;
                    end
                end
                ST_DONE: begin
                    cmd_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    // Unreachable encoding: return to a safe idle with the bus released.
                    cs_n_r      <= 1'b1;
                    tx_valid_r  <= 1'b0;
                    wait_rx_r   <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o    = cmd_ready_r;
    assign resp_valid_o   = resp_valid_r;
    assign resp_r1_o      = resp_r1_r;
    assign resp_timeout_o = resp_timeout_r;
    assign spi_cs_n_o     = cs_n_r;
    assign spi_tx_valid_o = tx_valid_r;
    assign spi_tx_byte_o  = tx_byte_r;

endmodule

// File: tb/tb_sdspi_cmd_seq.sv
// Directed bench for sdspi_cmd_seq with a small SPI byte-engine model:
// each accepted byte is echoed back as an rx pulse two cycles later, with
// the MISO byte taken from a per-test table (0xFF beyond the table).

module tb_sdspi_cmd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        card_present;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        resp_valid;
    logic [7:0]  resp_r1;
    logic        resp_timeout;
    logic        spi_cs_n;
    logic        spi_tx_valid;
    logic        spi_tx_ready;
    logic [7:0]  spi_tx_byte;
    logic        spi_rx_valid;
    logic [7:0]  spi_rx_byte;

    sdspi_cmd_seq #(.RESP_POLL_MAX(8), .PRE_BYTES(1), .POST_BYTES(1)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .card_present_i (card_present),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_idx_i      (cmd_idx),
        .cmd_arg_i      (cmd_arg),
        .resp_valid_o   (resp_valid),
        .resp_r1_o      (resp_r1),
        .resp_timeout_o (resp_timeout),
        .spi_cs_n_o     (spi_cs_n),
        .spi_tx_valid_o (spi_tx_valid),
        .spi_tx_ready_i (spi_tx_ready),
        .spi_tx_byte_o  (spi_tx_byte),
        .spi_rx_valid_i (spi_rx_valid),
        .spi_rx_byte_i  (spi_rx_byte)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] miso_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] mosi_q[$];
    int         n_rx;
    int         resp_cnt;
    int         resp_cyc;
    int         cs_bad;
    int         cs_low;
    logic [7:0] got_r1;
    logic       got_to;
    logic       got_cs_n;
    logic       got_ready;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the logged MOSI stream against the expected frame.
    task automatic check_frame(input string tag);
        check_eq({tag, "_len"}, mosi_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mosi_q.size(); i++) begin
            check_eq($sformatf("%s_b%0d", tag, i), mosi_q[i], exp_q[i]);
        end
    endtask

    // Issue one command and service the engine until the response (+4 cycles).
    // stall_idx/stall_len: hold ready low on that byte; abort_at: reset after that many bytes.
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic card,
                           input int stall_idx, input int stall_len, input logic [7:0] stall_byte,
                           input int abort_at, input logic hold_valid);
        int rx_delay;
        int stall_left;
        int after;
        rx_delay   = 0;
        stall_left = stall_len;
        after      = -1;
        n_rx       = 0;
        resp_cnt   = 0;
        resp_cyc   = -1;
        cs_bad     = 0;
        cs_low     = 0;
        got_r1     = 8'h00;
        got_to     = 1'b0;
        got_cs_n   = 1'b0;
        got_ready  = 1'b1;
        mosi_q.delete();
        card_present = card;
        cmd_idx      = idx;
        cmd_arg      = arg;
        @(negedge clk);
        cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (resp_valid) begin
                resp_cnt++;
                if (resp_cnt == 1) begin
                    got_r1    = resp_r1;
                    got_to    = resp_timeout;
                    got_cs_n  = spi_cs_n;
                    got_ready = cmd_ready;
                    resp_cyc  = cyc;
                    after     = 4;
                end
                cmd_valid = 1'b0;
            end
            if (cyc == 1 && !hold_valid) begin
                cmd_valid = 1'b0;
            end
            if (abort_at >= 0 && mosi_q.size() == abort_at) begin
                rst_n        = 1'b0;
                cmd_valid    = 1'b0;
                spi_rx_valid = 1'b0;
                spi_tx_ready = 1'b1;
                #1;
                check_eq("abort_cs_n", spi_cs_n, 1'b1);
                check_eq("abort_tx_valid", spi_tx_valid, 1'b0);
                check_eq("abort_ready", cmd_ready, 1'b1);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (resp_valid) resp_cnt++;
                end
                rst_n = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (resp_valid) resp_cnt++;
                end
                check_eq("abort_no_resp", resp_cnt, 0);
                return;
            end
            if (!spi_cs_n) cs_low++;
            if (spi_tx_valid && spi_cs_n) cs_bad++;
            spi_rx_valid = 1'b0;
            spi_rx_byte  = 8'hFF;
            if (rx_delay > 0) begin
                rx_delay--;
                if (rx_delay == 0) begin
                    spi_rx_valid = 1'b1;
                    spi_rx_byte  = (n_rx < miso_q.size()) ? miso_q[n_rx] : 8'hFF;
                    n_rx++;
                end
            end
            if (spi_tx_valid && mosi_q.size() == stall_idx && stall_left > 0) begin
                spi_tx_ready = 1'b0;
                stall_left--;
                check_eq("stall_hold", spi_tx_byte, stall_byte);
            end else begin
                spi_tx_ready = 1'b1;
                if (spi_tx_valid) begin
                    mosi_q.push_back(spi_tx_byte);
                    rx_delay = 2;
                end
            end
            if (after == 0) break;
            if (after > 0) after--;
            @(negedge clk);
        end
        spi_rx_valid = 1'b0;
        check_eq("resp_seen", (resp_cyc >= 0), 1'b1);
        check_eq("resp_once", resp_cnt, 1);
        check_eq("ready_low_done", got_ready, 1'b0);
        check_eq("cs_during_tx", cs_bad, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        card_present = 1'b1;
        cmd_valid    = 1'b0;
        cmd_idx      = 6'd0;
        cmd_arg      = 32'd0;
        spi_tx_ready = 1'b1;
        spi_rx_valid = 1'b0;
        spi_rx_byte  = 8'hFF;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", cmd_ready, 1'b1);
        check_eq("rst_resp_valid", resp_valid, 1'b0);
        check_eq("rst_r1", resp_r1, 8'hFF);
        check_eq("rst_timeout", resp_timeout, 1'b0);
        check_eq("rst_cs_n", spi_cs_n, 1'b1);
        check_eq("rst_tx_valid", spi_tx_valid, 1'b0);
        check_eq("rst_tx_byte", spi_tx_byte, 8'hFF);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: CMD0, R1=01 on the second poll byte.
        miso_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hFF};
        exp_q  = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
        run_cmd(6'd0, 32'd0, 1'b1, -1, 0, 8'h00, -1, 1'b0);
        check_frame("t1");
        check_eq("t1_r1", got_r1, 8'h01);
        check_eq("t1_to", got_to, 1'b0);
        check_eq("t1_cs_at_resp", got_cs_n, 1'b1);
        check_eq("t1_r1_held", resp_r1, 8'h01);

        // 2: CMD8 0x1AA, R1=01 on the first poll byte.
        miso_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hFF};
        exp_q  = '{8'hFF, 8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87, 8'hFF, 8'hFF};
        run_cmd(6'd8, 32'h0000_01AA, 1'b1, -1, 0, 8'h00, -1, 1'b0);
        check_frame("t2");
        check_eq("t2_r1", got_r1, 8'h01);
        check_eq("t2_to", got_to, 1'b0);

        // 3: CMD55, card never answers; cmd_valid held high while busy.
        miso_q.delete();
        exp_q = '{8'hFF, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h65,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_cmd(6'd55, 32'd0, 1'b1, -1, 0, 8'h00, -1, 1'b1);
        check_frame("t3");
        check_eq("t3_r1", got_r1, 8'hFF);
        check_eq("t3_to", got_to, 1'b1);
        check_eq("t3_cs_at_resp", got_cs_n, 1'b1);

        // 4: no card -> no SPI traffic, quick timeout response.
        miso_q.delete();
        exp_q.delete();
        run_cmd(6'd17, 32'h0000_0200, 1'b0, -1, 0, 8'h00, -1, 1'b0);
        check_frame("t4");
        check_eq("t4_cs_low", cs_low, 0);
        check_eq("t4_latency", (resp_cyc >= 0 && resp_cyc <= 3), 1'b1);
        check_eq("t4_r1", got_r1, 8'hFF);
        check_eq("t4_to", got_to, 1'b1);
        card_present = 1'b1;

        // 5: backpressure on the CRC byte for 5 cycles.
        miso_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hFF};
        exp_q  = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
        run_cmd(6'd0, 32'd0, 1'b1, 6, 5, 8'h95, -1, 1'b0);
        check_frame("t5");
        check_eq("t5_r1", got_r1, 8'h01);
        check_eq("t5_to", got_to, 1'b0);

        // 6: reset during the argument bytes, then a clean CMD0.
        run_cmd(6'd0, 32'd0, 1'b1, -1, 0, 8'h00, 3, 1'b0);
        run_cmd(6'd0, 32'd0, 1'b1, -1, 0, 8'h00, -1, 1'b0);
        check_frame("t6");
        check_eq("t6_r1", got_r1, 8'h01);
        check_eq("t6_to", got_to, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
